// File: rtl/sum_window_pkg.sv
// Shared types and defaults for the windowed sum/min/max statistics stage.
package sum_window_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WIN    = 16;
    localparam int DEF_ACC_W  = 12;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_window_accum_minmax.sv
// Running unsigned min/max tracker. Exposes both the registered values and the
// values that would result from folding in the current sample.
module minmax_track #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              update,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_next,
    output logic [DATA_W-1:0] max_next
);

    logic [DATA_W-1:0] min_reg;
    logic [DATA_W-1:0] max_reg;

    always_comb begin
        min_next = (data < min_reg) ? data : min_reg;
        max_next = (data > max_reg) ? data : max_reg;
    end

    // init wins over update so a window boundary always starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (init) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (update) begin
            min_reg <= min_next;
            max_reg <= max_next;
        end
    end

    assign min_val = min_reg;
    assign max_val = max_reg;

endmodule

// File: rtl/sum_window_accum.sv
// Accumulates WIN adder sums per window and presents total/min/max to the
// next stage, holding the result until it is accepted.
module sum_window_accum
    import sum_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN    = DEF_WIN,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [7:0]        win_cnt
);

    generate
        if (ACC_W < DATA_W + clog2(WIN)) begin : g_bad_acc_w
            $error("sum_window_accum: ACC_W too narrow for DATA_W and WIN");
        end
        if (WIN < 2 || WIN > 256) begin : g_bad_win
            $error("sum_window_accum: WIN out of range 2..256");
        end
    endgenerate

    localparam logic [7:0] LAST_CNT = 8'(WIN - 1);

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic [7:0]        cnt_reg;
    logic [ACC_W-1:0]  out_sum_reg;
    logic [DATA_W-1:0] out_min_reg;
    logic [DATA_W-1:0] out_max_reg;

    logic              in_xfer;
    logic              win_done;
    logic              mm_init;
    logic              mm_update;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);

    assign in_xfer   = in_valid & in_ready;
    assign win_done  = in_xfer & (cnt_reg == LAST_CNT);
    assign acc_next  = acc_reg + ACC_W'(in_data);

    // A sample that coincides with clear is dropped, so clear also blocks update.
    assign mm_init   = clear | win_done;
    assign mm_update = in_xfer & ~clear;

    minmax_track #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (mm_init),
        .update   (mm_update),
        .data     (in_data),
        .min_val  (run_min),
        .max_val  (run_max),
        .min_next (min_next),
        .max_next (max_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            out_sum_reg <= '0;
            out_min_reg <= '1;
            out_max_reg <= '0;
        end else if (clear) begin
            // Abort: result registers keep their last value on purpose.
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (win_done) begin
                        out_sum_reg <= acc_next;
                        out_min_reg <= min_next;
                        out_max_reg <= max_next;
                        acc_reg     <= '0;
                        cnt_reg     <= '0;
                        state_reg   <= HOLD;
                    end else if (in_xfer) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign out_sum = out_sum_reg;
    assign out_min = out_min_reg;
    assign out_max = out_max_reg;
    assign win_cnt = cnt_reg;

endmodule

// File: tb/tb_sum_window_accum.sv
// Directed bench for sum_window_accum: table of full windows plus hand-written
// backpressure, clear and asynchronous reset sequences.
module tb_sum_window_accum;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [7:0]  out_min;
    logic [7:0]  out_max;
    logic [7:0]  win_cnt;

    int n_vec;
    int n_err;

    sum_window_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_min   (out_min),
        .out_max   (out_max),
        .win_cnt   (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int start;
        int step;
        int exp_sum;
        int exp_min;
        int exp_max;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},  32'(in_ready),  32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_sum"},   32'(out_sum),   32'd0);
        check({tag, " out_min"},   32'(out_min),   32'hFF);
        check({tag, " out_max"},   32'(out_max),   32'd0);
        check({tag, " win_cnt"},   32'(win_cnt),   32'd0);
    endtask

    // Feeds n samples start, start+step, ... checking win_cnt/in_ready before each edge.
    task automatic feed(input int start, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(start + step * i);
            check($sformatf("cnt[%0d]", i), 32'(win_cnt), 32'(i));
            check($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int s, input int mn, input int mx);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " in_ready"},  32'(in_ready),  32'd0);
        check({tag, " win_cnt"},   32'(win_cnt),   32'd0);
        check({tag, " out_sum"},   32'(out_sum),   32'(s));
        check({tag, " out_min"},   32'(out_min),   32'(mn));
        check({tag, " out_max"},   32'(out_max),   32'(mx));
        $display("%s: sum=%0d min=%0d max=%0d valid=%0b", tag, out_sum, out_min, out_max, out_valid);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{start: 'h10, step: 0,  exp_sum: 256,  exp_min: 'h10, exp_max: 'h10};
        vecs[1] = '{start: 0,    step: 1,  exp_sum: 120,  exp_min: 0,    exp_max: 15};
        vecs[2] = '{start: 15,   step: -1, exp_sum: 120,  exp_min: 0,    exp_max: 15};
        vecs[3] = '{start: 'hFF, step: 0,  exp_sum: 4080, exp_min: 'hFF, exp_max: 'hFF};
        vecs[4] = '{start: 1,    step: 0,  exp_sum: 16,   exp_min: 1,    exp_max: 1};
        vecs[5] = '{start: 128,  step: 8,  exp_sum: 3008, exp_min: 128,  exp_max: 248};
        vecs[6] = '{start: 0,    step: 17, exp_sum: 2040, exp_min: 0,    exp_max: 255};

        #12;
        check_reset_values("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Table of back-to-back windows with out_ready tied high.
        for (int v = 0; v < 7; v++) begin
            feed(vecs[v].start, vecs[v].step, 16);
            check_result($sformatf("win%0d", v), vecs[v].exp_sum, vecs[v].exp_min, vecs[v].exp_max);
            tick();
            check($sformatf("win%0d pulse", v), 32'(out_valid), 32'd0);
        end

        // Backpressure: result held for 5 cycles, in_valid ignored in HOLD.
        out_ready = 1'b0;
        feed(3, 2, 16);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            check_result($sformatf("hold%0d", c), 288, 3, 33);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold release valid", 32'(out_valid), 32'd0);
        check("hold release cnt",   32'(win_cnt),   32'd0);
        check("hold keep sum",      32'(out_sum),   32'd288);

        // clear after 7 samples; the sample presented with clear is discarded.
        feed('h50, 0, 7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h50;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear cnt",      32'(win_cnt), 32'd0);
        check("clear keep sum", 32'(out_sum), 32'd288);
        feed(1, 0, 16);
        check_result("after clear", 16, 1, 1);
        tick();

        // clear in HOLD drops the pending result without a handshake.
        out_ready = 1'b0;
        feed('h20, 0, 16);
        check_result("pre clear hold", 512, 'h20, 'h20);
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b1;
        check("clear hold valid", 32'(out_valid), 32'd0);
        check("clear hold ready", 32'(in_ready),  32'd1);
        check("clear hold sum",   32'(out_sum),   32'd512);
        tick();
        check("clear hold stays", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-window.
        feed(7, 0, 9);
        check("pre rst cnt", 32'(win_cnt), 32'd9);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst mid");
        tick();
        rst_n = 1'b1;
        feed(2, 0, 16);
        check_result("after rst", 32, 2, 2);
        tick();

        // Asynchronous reset in HOLD.
        out_ready = 1'b0;
        feed(9, 1, 16);
        check_result("pre rst hold", 264, 9, 24);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst hold");
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        feed(4, 0, 16);
        check_result("final", 64, 4, 4);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
